// File: rtl/rom_server_pkg.sv
`default_nettype none
//==============================================================================
//  Module   : rom_server_pkg
//  Purpose  : Shared definitions for the ROM server: FSM state encoding and
//             the backing-memory region constants that form the top bit of
//             the backing-memory address.
//  Contents : state_t  - IDLE / ISSUE / RESP
//             REG_PRG  - region 0, PRG ROM
//             REG_CHR  - region 1, CHR ROM
//  Revision : 1.0 - initial release
//==============================================================================
package rom_server_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic REG_PRG = 1'b0;
    localparam logic REG_CHR = 1'b1;

endpackage : rom_server_pkg
`default_nettype wire

// File: rtl/rom_arb2.sv
`default_nettype none
//==============================================================================
//  Module   : rom_arb2
//  Purpose  : Two-way round-robin grant between the PRG and CHR clients.
//             When both are eligible, the client that was not served last
//             wins; a lone eligible client always wins.
//  Ports    : req_prg   in  PRG eligible request
//             req_chr   in  CHR eligible request
//             last_chr  in  1 = CHR was served last, 0 = PRG was served last
//             gnt_valid out some client is granted
//             gnt_chr   out 1 = CHR granted, 0 = PRG granted (valid with gnt_valid)
//  Revision : 1.0 - initial release
//==============================================================================
module rom_arb2 (
    input  logic req_prg,
    input  logic req_chr,
    input  logic last_chr,
    output logic gnt_valid,
    output logic gnt_chr
);

    always_comb begin
        gnt_valid = req_prg | req_chr;
        // CHR wins if it is the only requester, or on a tie when PRG went last.
        gnt_chr   = req_chr & (~req_prg | ~last_chr);
    end

endmodule : rom_arb2
`default_nettype wire

// File: rtl/rom_server.sv
`default_nettype none
//==============================================================================
//  Module   : rom_server
//  Purpose  : Serves PRG and CHR ROM read requests from a single backing
//             memory, one transaction at a time, with round-robin arbitration.
//             Backing address is {region, client address}; region 0 = PRG,
//             region 1 = CHR.
//  Options  : ROMSRV_HITCACHE_EN - adds a per-client last-read register; a
//             request that repeats the last completed address is answered
//             from it without touching the backing memory.
//  Ports    : clk                 in   rising-edge clock
//             rstn                in   asynchronous active-low reset
//             promaddr/promreq    in   PRG address / request level
//             promack/promdata    out  PRG one-cycle ack / read data
//             cromaddr/cromreq    in   CHR address / request level
//             cromack/cromdata    out  CHR one-cycle ack / read data
//             ramaddr/ramreq      out  backing-memory address / request level
//             ramack/ramrdata     in   backing-memory one-cycle ack / data
//  Revision : 1.0 - initial release
//==============================================================================
module rom_server #(
    parameter int AW = 21,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] promaddr,
    input  logic          promreq,
    output logic          promack,
    output logic [DW-1:0] promdata,
    input  logic [AW-1:0] cromaddr,
    input  logic          cromreq,
    output logic          cromack,
    output logic [DW-1:0] cromdata,
    output logic [AW:0]   ramaddr,
    output logic          ramreq,
    input  logic          ramack,
    input  logic [DW-1:0] ramrdata
);

    import rom_server_pkg::*;

    state_t        r_state;
    logic          r_last_chr;   // last granted client; also the client in service
    logic          r_from_resp;  // this IDLE cycle directly follows an ack
    logic [DW-1:0] r_data;

    logic          w_elig_prg;
    logic          w_elig_chr;
    logic          w_gnt_valid;
    logic          w_gnt_chr;
    logic [AW-1:0] w_gnt_addr;
    logic          w_hit;
    logic [DW-1:0] w_hit_data;

    // The client acked in the previous cycle sits out this IDLE cycle, so a
    // re-raised request cannot be confused with the one just completed.
    assign w_elig_prg = promreq & ~(r_from_resp & (r_last_chr == REG_PRG));
    assign w_elig_chr = cromreq & ~(r_from_resp & (r_last_chr == REG_CHR));

    rom_arb2 u_arb (
        .req_prg   (w_elig_prg),
        .req_chr   (w_elig_chr),
        .last_chr  (r_last_chr),
        .gnt_valid (w_gnt_valid),
        .gnt_chr   (w_gnt_chr)
    );

    assign w_gnt_addr = w_gnt_chr ? cromaddr : promaddr;

    // Both clients see the one data register; each only trusts it with its ack.
    assign promdata = r_data;
    assign cromdata = r_data;

`ifdef ROMSRV_HITCACHE_EN
    logic [1:0]    r_hit_valid;
    logic [AW-1:0] r_hit_addr [2];
    logic [DW-1:0] r_hit_data [2];

    // Every completed miss refreshes the owning client's entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hit_valid <= '0;
            for (int i = 0; i < 2; i++) begin
                r_hit_addr[i] <= '0;
                r_hit_data[i] <= '0;
            end
        end else if (r_state == ISSUE && ramack) begin
            r_hit_valid[r_last_chr] <= 1'b1;
            r_hit_addr[r_last_chr]  <= ramaddr[AW-1:0];
            r_hit_data[r_last_chr]  <= ramrdata;
        end
    end

    assign w_hit      = r_hit_valid[w_gnt_chr] && (r_hit_addr[w_gnt_chr] == w_gnt_addr);
    assign w_hit_data = r_hit_data[w_gnt_chr];
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_last_chr  <= REG_CHR;   // PRG wins the first tie
            r_from_resp <= 1'b0;
            r_data      <= '0;
            ramreq      <= 1'b0;
            ramaddr     <= '0;
            promack     <= 1'b0;
            cromack     <= 1'b0;
        end else begin
            // Acks are single-cycle pulses raised only on entry to RESP.
            promack     <= 1'b0;
            cromack     <= 1'b0;
            r_from_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_last_chr <= w_gnt_chr;
                        if (w_hit) begin
                            r_data  <= w_hit_data;
                            promack <= ~w_gnt_chr;
                            cromack <= w_gnt_chr;
                            r_state <= RESP;
                        end else begin
                            ramaddr <= {(w_gnt_chr ? REG_CHR : REG_PRG), w_gnt_addr};
                            ramreq  <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // ramaddr is untouched here, so it stays stable until ramack.
                    if (ramack) begin
                        r_data  <= ramrdata;
                        ramreq  <= 1'b0;
                        promack <= ~r_last_chr;
                        cromack <= r_last_chr;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_from_resp <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : rom_server
`default_nettype wire
